// File: rtl/fp_alu_pkg.sv
// Shared types and constants for the FP ALU add/sub path.
package fp_alu_pkg;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned SIG_W = 25;

   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] FP_INF_MAG = 32'h7F80_0000;
   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

   typedef enum logic [2:0] {
      StIdle,
      StAlign,
      StAdd,
      StNorm,
      StDone
   } fp_state_e;

   // Exponent 0 means zero magnitude: no denormals, so the whole significand is cleared.
   function automatic logic [SIG_W-2:0] fp_sig(input logic [30:0] v);
      if (v[30:MAN_W] == '0) begin
         return '0;
      end
      return {1'b1, v[MAN_W-1:0]};
   endfunction

endpackage

// File: rtl/fp_norm_step.sv
// One normalization step: a single right shift on carry-out or a single left shift.
module fp_norm_step
   import fp_alu_pkg::*;
(
   input  logic [SIG_W-1:0] sum_i,
   input  logic [EXP_W-1:0] exp_i,
   output logic [SIG_W-1:0] sum_o,
   output logic [EXP_W-1:0] exp_o,
   output logic             done_o,
   output logic             ovf_o,
   output logic             udf_o
);

   logic [EXP_W:0] exp_inc;
   logic [EXP_W:0] exp_dec;

   always_comb begin
      exp_inc = {1'b0, exp_i} + (EXP_W+1)'(1);
      exp_dec = {1'b0, exp_i} - (EXP_W+1)'(1);
      sum_o   = sum_i;
      exp_o   = exp_i;
      done_o  = 1'b1;
      ovf_o   = 1'b0;
      udf_o   = 1'b0;
      if (sum_i[SIG_W-1]) begin
         sum_o = sum_i >> 1;
         exp_o = exp_inc[EXP_W-1:0];
         ovf_o = (exp_inc >= (EXP_W+1)'(255));
      end else if (!sum_i[SIG_W-2]) begin
         sum_o  = sum_i << 1;
         exp_o  = exp_dec[EXP_W-1:0];
         // Finished once the bit about to land in position 23 is set.
         done_o = sum_i[SIG_W-3];
         udf_o  = (exp_i <= EXP_W'(1));
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle single-precision add/sub: serial alignment and normalization, truncation rounding.
// Optional FP_ADDSUB_SPECIALS_EN: Inf/NaN operands bypass the datapath straight to DONE.
module fp_addsub_seq
   import fp_alu_pkg::*;
#(
   parameter int unsigned ALIGN_CAP = 25,
   parameter int unsigned NORM_MAX  = 24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a_operand,
   input  logic [31:0] b_operand,
   input  logic        op_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   fp_state_e        state_q;
   logic             sign_q;
   logic             effsub_q;
   logic [EXP_W-1:0] exp_q;
   logic [EXP_W-1:0] d_q;
   logic [SIG_W-2:0] mx_q;
   logic [SIG_W-2:0] my_q;
   logic [SIG_W-1:0] sum_q;
   logic [7:0]       cnt_q;
   logic [31:0]      result_q;

   logic [31:0]      b_eff;
   logic [31:0]      x_op;
   logic [31:0]      y_op;
   logic [SIG_W-1:0] sum_add;

   logic [SIG_W-1:0] ns_sum;
   logic [EXP_W-1:0] ns_exp;
   logic             ns_done;
   logic             ns_ovf;
   logic             ns_udf;

   // Larger magnitude goes to X; comparing {exp, mantissa} orders by exponent, then mantissa.
   always_comb begin
      b_eff = {b_operand[31] ^ op_sub, b_operand[30:0]};
      if (a_operand[30:0] >= b_eff[30:0]) begin
         x_op = a_operand;
         y_op = b_eff;
      end else begin
         x_op = b_eff;
         y_op = a_operand;
      end
      if (effsub_q) begin
         sum_add = {1'b0, mx_q} - {1'b0, my_q};
      end else begin
         sum_add = {1'b0, mx_q} + {1'b0, my_q};
      end
   end

`ifdef FP_ADDSUB_SPECIALS_EN
   logic        a_max_exp;
   logic        b_max_exp;
   logic        is_special;
   logic [31:0] special_res;

   always_comb begin
      a_max_exp  = (a_operand[30:23] == 8'hFF);
      b_max_exp  = (b_eff[30:23] == 8'hFF);
      is_special = a_max_exp || b_max_exp;
      if ((a_max_exp && a_operand[22:0] != '0) || (b_max_exp && b_eff[22:0] != '0)) begin
         special_res = FP_QNAN;
      end else if (a_max_exp && b_max_exp && (a_operand[31] != b_eff[31])) begin
         special_res = FP_QNAN;
      end else if (a_max_exp) begin
         special_res = {a_operand[31], FP_INF_MAG[30:0]};
      end else begin
         special_res = {b_eff[31], FP_INF_MAG[30:0]};
      end
   end
`endif

   fp_norm_step u_norm_step (
      .sum_i  (sum_q),
      .exp_i  (exp_q),
      .sum_o  (ns_sum),
      .exp_o  (ns_exp),
      .done_o (ns_done),
      .ovf_o  (ns_ovf),
      .udf_o  (ns_udf)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         sign_q   <= 1'b0;
         effsub_q <= 1'b0;
         exp_q    <= '0;
         d_q      <= '0;
         mx_q     <= '0;
         my_q     <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         result_q <= FP_ZERO;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  sign_q   <= x_op[31];
                  effsub_q <= x_op[31] ^ y_op[31];
                  exp_q    <= x_op[30:23];
                  d_q      <= x_op[30:23] - y_op[30:23];
                  mx_q     <= fp_sig(x_op[30:0]);
                  my_q     <= fp_sig(y_op[30:0]);
`ifdef FP_ADDSUB_SPECIALS_EN
                  if (is_special) begin
                     result_q <= special_res;
                     state_q  <= StDone;
                  end else begin
                     state_q <= StAlign;
                  end
`else
                  state_q <= StAlign;
`endif
               end
            end
            StAlign: begin
               if (d_q == '0) begin
                  state_q <= StAdd;
               end else if (32'(d_q) >= ALIGN_CAP) begin
                  my_q    <= '0;
                  state_q <= StAdd;
               end else begin
                  my_q <= my_q >> 1;
                  d_q  <= d_q - EXP_W'(1);
                  if (d_q == EXP_W'(1)) begin
                     state_q <= StAdd;
                  end
               end
            end
            StAdd: begin
               if (sum_add == '0) begin
                  result_q <= FP_ZERO;
                  state_q  <= StDone;
               end else begin
                  sum_q   <= sum_add;
                  cnt_q   <= '0;
                  state_q <= StNorm;
               end
            end
            StNorm: begin
               cnt_q <= cnt_q + 8'd1;
               if (ns_ovf) begin
                  result_q <= {sign_q, FP_INF_MAG[30:0]};
                  state_q  <= StDone;
               end else if (ns_udf || (!ns_done && (32'(cnt_q) + 32'd1 > NORM_MAX))) begin
                  result_q <= FP_ZERO;
                  state_q  <= StDone;
               end else if (ns_done) begin
                  result_q <= {sign_q, ns_exp, ns_sum[MAN_W-1:0]};
                  state_q  <= StDone;
               end else begin
                  sum_q <= ns_sum;
                  exp_q <= ns_exp;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready  = (state_q == StIdle) && !reset;
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed cases from the test plan plus random operands.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        op_sub = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a_operand = '0;
   logic [31:0] b_operand = '0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [31:0] result;

   always #5 clk = ~clk;

   fp_addsub_seq #(
      .ALIGN_CAP (25),
      .NORM_MAX  (24)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_operand (a_operand),
      .b_operand (b_operand),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          edges = 0;
   int          rdy_mode = 0;
   bit          inflight = 1'b0;
   bit          busy_bad = 1'b0;
   bit          got = 1'b0;
   bit          prev_ov = 1'b0;
   bit          prev_ordy = 1'b0;
   logic [31:0] prev_res = '0;

   always @(posedge clk) edges <= edges + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
      end
   endtask

   // Reference: real-number rules on integer significands, latency from the per-phase cycle rules.
   function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                     output logic [31:0] res, output int lat);
      logic [31:0] be, x, y;
      int          ex, ey, d, sh, p, align_c;
      longint      mx, my, sum;
      logic        s;
      be = {b[31] ^ sub, b[30:0]};
`ifdef FP_ADDSUB_SPECIALS_EN
      if (a[30:23] == 8'hFF || be[30:23] == 8'hFF) begin
         lat = 1;
         if ((a[30:23] == 8'hFF && a[22:0] != 0) || (be[30:23] == 8'hFF && be[22:0] != 0))
            res = 32'h7FC00000;
         else if (a[30:23] == 8'hFF && be[30:23] == 8'hFF && a[31] != be[31])
            res = 32'h7FC00000;
         else if (a[30:23] == 8'hFF)
            res = {a[31], 31'h7F800000};
         else
            res = {be[31], 31'h7F800000};
         return;
      end
`endif
      if (a[30:0] >= be[30:0]) begin
         x = a;
         y = be;
      end else begin
         x = be;
         y = a;
      end
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = (ex == 0) ? 64'd0 : longint'({1'b1, x[22:0]});
      my = (ey == 0) ? 64'd0 : longint'({1'b1, y[22:0]});
      d = ex - ey;
      align_c = (d == 0 || d >= 25) ? 1 : d;
      my = (d >= 25) ? 64'd0 : (my >> d);
      s = x[31];
      sum = (x[31] != y[31]) ? (mx - my) : (mx + my);
      if (sum == 0) begin
         res = 32'h0;
         lat = align_c + 1;
         return;
      end
      if (sum >= (64'd1 << 24)) begin
         lat = align_c + 2;
         if (ex + 1 >= 255) res = {s, 31'h7F800000};
         else res = {s, 8'(ex + 1), 23'(sum >> 1)};
         return;
      end
      p = 0;
      for (int k = 0; k < 24; k++) if (sum[k]) p = k;
      sh = 23 - p;
      if (ex - sh <= 0) begin
         res = 32'h0;
         lat = align_c + 1 + ex;
         return;
      end
      res = {s, 8'(ex - sh), 23'(sum << sh)};
      lat = align_c + 1 + ((sh == 0) ? 1 : sh);
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input bit chk,
                       input string name);
      int          guard = 0;
      logic [31:0] r;
      int          l;
      exp_t        e;
      @(negedge clk);
      while (!in_ready && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s/accept: in_ready=0, expected 1", name);
         return;
      end
      a_operand = a;
      b_operand = b;
      op_sub = sub;
      in_valid = 1'b1;
      ref_model(a, b, sub, r, l);
      e.res = r;
      e.lat = l;
      e.acc = edges;
      e.name = name;
      if (chk) begin
         sb.push_back(e);
         busy_bad = 1'b0;
         inflight = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_operand = $urandom();
      b_operand = $urandom();
   endtask

   task automatic wait_idle(input string name);
      int i = 0;
      while ((sb.size() != 0 || inflight || !in_ready) && i < 3000) begin
         @(negedge clk);
         i++;
      end
      if (sb.size() != 0 || inflight || !in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s/drain: %0d results outstanding, expected 0", name, sb.size());
      end
   endtask

   // Consumer backpressure: 0 random, 1 stall, 2 always ready.
   initial forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
         0: out_ready = ($urandom_range(0, 2) != 0);
         1: out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   initial forever begin
      @(negedge clk);
      if (reset) begin
         got = 1'b0;
         prev_ov = 1'b0;
      end else begin
         if (inflight && !out_valid && !busy) busy_bad = 1'b1;
         if (prev_ov && !prev_ordy) check("hold/out_valid", {31'b0, out_valid}, 32'd1);
         if (prev_ov && prev_ordy) check("release/out_valid", {31'b0, out_valid}, 32'd0);
         if (out_valid) begin
            if (!got) begin
               got = 1'b1;
               inflight = 1'b0;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: got 0x%08h, expected no output", result);
               end else begin
                  mon_e = sb.pop_front();
                  check({mon_e.name, "/result"}, result, mon_e.res);
                  check({mon_e.name, "/latency"}, 32'(edges - mon_e.acc - 1), 32'(mon_e.lat));
                  check({mon_e.name, "/busy"}, {31'b0, busy_bad}, 32'd0);
               end
            end else if (prev_ov && !prev_ordy) begin
               check("hold/result", result, prev_res);
               check("hold/in_ready", {31'b0, in_ready}, 32'd0);
            end
            prev_res = result;
         end else begin
            got = 1'b0;
         end
         prev_ov = out_valid;
         prev_ordy = out_ready;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ra, rb;
      int          ea, eb;
      repeat (2) @(negedge clk);
      #1;
      check("reset/in_ready", {31'b0, in_ready}, 32'd0);
      check("reset/out_valid", {31'b0, out_valid}, 32'd0);
      check("reset/busy", {31'b0, busy}, 32'd0);
      check("reset/result", result, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_release/in_ready", {31'b0, in_ready}, 32'd1);

      send(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, "one_plus_one");
      send(32'h40400000, 32'h3F800000, 1'b1, 1'b1, "three_minus_one");
      send(32'h3F800001, 32'h3F800000, 1'b1, 1'b1, "cancel_23");
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, "overflow_inf");
      send(32'h3F800000, 32'h33800000, 1'b0, 1'b1, "align_24");
      send(32'h4E800000, 32'h3F800000, 1'b0, 1'b1, "align_cap");
      send(32'hBF800000, 32'h3F800000, 1'b1, 1'b1, "neg_sum");
      send(32'h3F800000, 32'h3F800000, 1'b1, 1'b1, "exact_zero");
      send(32'h00C00000, 32'h00800000, 1'b1, 1'b1, "underflow");

      wait_idle("pre_hold");
      rdy_mode = 1;
      send(32'h40400000, 32'h3F800000, 1'b0, 1'b1, "hold_case");
      for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
      check("hold/appear", {31'b0, out_valid}, 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("hold/stall_valid", {31'b0, out_valid}, 32'd1);
         check("hold/stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      rdy_mode = 2;
      @(posedge clk);
      #3;
      @(posedge clk);
      @(negedge clk);
      check("hold/idle_next_edge", {30'b0, out_valid, in_ready}, 32'd1);
      rdy_mode = 0;

      wait_idle("pre_reset");
      send(32'h3F800001, 32'h3F800000, 1'b1, 1'b0, "aborted");
      repeat (8) @(negedge clk);
      check("midnorm/busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("midnorm_reset/out_valid", {31'b0, out_valid}, 32'd0);
      check("midnorm_reset/result", result, 32'h0);
      check("midnorm_reset/busy", {31'b0, busy}, 32'd0);
      check("midnorm_reset/in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midnorm_release/in_ready", {31'b0, in_ready}, 32'd1);
      send(32'h3F800000, 32'h3F800000, 1'b0, 1'b1, "after_reset");

`ifdef FP_ADDSUB_SPECIALS_EN
      send(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, "inf_minus_inf");
      send(32'h7F800000, 32'h3F800000, 1'b1, 1'b1, "inf_minus_one");
      send(32'h3F800000, 32'h7F800000, 1'b1, 1'b1, "one_minus_inf");
      send(32'h7F800001, 32'h3F800000, 1'b0, 1'b1, "nan_in");
`endif

      for (int i = 0; i < 150; i++) begin
         ra = $urandom();
         ea = int'($urandom_range(1, 254));
         if ($urandom_range(0, 15) == 0) ea = ($urandom_range(0, 1) != 0) ? 0 : 255;
         eb = ea + int'($urandom_range(0, 60)) - 30;
         if (eb < 0) eb = 0;
         if (eb > 255) eb = 255;
         ra[30:23] = 8'(ea);
         rb = $urandom();
         rb[30:23] = 8'(eb);
         if ($urandom_range(0, 7) == 0) rb[30:0] = ra[30:0];
         if ($urandom_range(0, 9) == 0) rb[30:23] = 8'($urandom_range(0, 255));
         send(ra, rb, 1'($urandom_range(0, 1)), 1'b1, "rand");
      end

      wait_idle("final");
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
